// File: rtl/main_fsm.sv
// Multicycle RISC-V style main control FSM: sequences fetch, decode and
// per-opcode execute/writeback states, driving datapath selects and enables.
module main_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       zero,
  output logic [1:0] aluop,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       illegal
);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BEQ, JAL
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  typedef struct packed {
    logic [1:0] aluop;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       adrsrc;
    logic       irwrite;
    logic       regwrite;
    logic       memwrite;
    logic       pcupdate;
    logic       branch;
  } ctrl_t;

  function automatic ctrl_t decode_ctrl(state_t s);
    ctrl_t c;
    c = '0;
    case (s)
      FETCH:    begin c.alusrcb = 2'b10; c.resultsrc = 2'b10; c.irwrite = 1'b1; c.pcupdate = 1'b1; end
      DECODE:   begin c.alusrca = 2'b01; c.alusrcb = 2'b01; end
      MEMADR:   begin c.alusrca = 2'b10; c.alusrcb = 2'b01; end
      MEMREAD:  c.adrsrc = 1'b1;
      MEMWB:    begin c.resultsrc = 2'b01; c.regwrite = 1'b1; end
      MEMWRITE: begin c.adrsrc = 1'b1; c.memwrite = 1'b1; end
      EXECR:    begin c.alusrca = 2'b10; c.aluop = 2'b10; end
      EXECI:    begin c.alusrca = 2'b10; c.alusrcb = 2'b01; c.aluop = 2'b10; end
      ALUWB:    c.regwrite = 1'b1;
      BEQ:      begin c.alusrca = 2'b10; c.aluop = 2'b01; c.branch = 1'b1; end
      JAL:      begin c.alusrca = 2'b01; c.alusrcb = 2'b10; c.pcupdate = 1'b1; end
      default:  c = '0;
    endcase
    return c;
  endfunction

  state_t state, next_state;
  ctrl_t  ctrl;
  logic   op_known;

  always_comb begin
    op_known = (op == OP_LW) || (op == OP_SW) || (op == OP_R) ||
               (op == OP_I)  || (op == OP_BEQ) || (op == OP_JAL);
    next_state = FETCH;
    case (state)
      FETCH:  next_state = DECODE;
      DECODE: begin
        if (op == OP_LW || op == OP_SW) next_state = MEMADR;
        else if (op == OP_R)            next_state = EXECR;
        else if (op == OP_I)            next_state = EXECI;
        else if (op == OP_BEQ)          next_state = BEQ;
        else if (op == OP_JAL)          next_state = JAL;
        else                            next_state = FETCH;
      end
      MEMADR:   next_state = (op == OP_LW) ? MEMREAD : MEMWRITE;
      MEMREAD:  next_state = MEMWB;
      EXECR, EXECI, JAL: next_state = ALUWB;
      default:  next_state = FETCH;
    endcase
  end

  // Control word is registered alongside the state so outputs come straight from flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
      ctrl  <= decode_ctrl(FETCH);
    end else begin
      state <= next_state;
      ctrl  <= decode_ctrl(next_state);
    end
  end

  // Enables are masked while reset is held; selects already show FETCH values.
  assign aluop     = ctrl.aluop;
  assign alusrca   = ctrl.alusrca;
  assign alusrcb   = ctrl.alusrcb;
  assign resultsrc = ctrl.resultsrc;
  assign adrsrc    = ctrl.adrsrc;
  assign irwrite   = ctrl.irwrite  & ~reset;
  assign regwrite  = ctrl.regwrite & ~reset;
  assign memwrite  = ctrl.memwrite & ~reset;
  assign pcwrite   = (ctrl.pcupdate | (ctrl.branch & zero)) & ~reset;
  assign illegal   = (state == DECODE) & ~op_known & ~reset;

endmodule

// File: doc/main_fsm.md
MAIN_FSM -- requirements
Module: main_fsm

Interface
REQ-001 The block SHALL have no parameters; all encodings below are fixed.
REQ-002 The block SHALL have the following ports, clock and reset first:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- op  in  7  instruction opcode, instr[6:0]
- zero  in  1  ALU zero flag
- aluop  out  2  to ALU decoder: 00 add, 01 sub, 10 funct-decoded
- alusrca  out  2  00 PC, 01 oldPC, 10 rs1 data
- alusrcb  out  2  00 rs2 data, 01 immediate, 10 constant 4
- resultsrc  out  2  00 ALUOut, 01 read data, 10 ALU result
- adrsrc  out  1  memory address: 0 PC, 1 result
- irwrite  out  1  instruction register enable
- pcwrite  out  1  PC register enable
- regwrite  out  1  register file write enable
- memwrite  out  1  data memory write enable
- illegal  out  1  one-cycle pulse: unsupported opcode decoded

Function
REQ-003 The block SHALL be a Moore FSM with 11 states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL; aluop, the selects and the enables except pcwrite depend only on state.
REQ-004 The state register SHALL advance one state per rising clk edge; there are no stall inputs.
REQ-005 Transitions SHALL be:
- FETCH->DECODE
- DECODE: op 0000011 or 0100011 ->MEMADR; 0110011 ->EXECR; 0010011 ->EXECI; 1100011 ->BEQ; 1101111 ->JAL; any other op ->FETCH
- MEMADR: op 0000011 ->MEMREAD, otherwise ->MEMWRITE
- MEMREAD->MEMWB->FETCH; MEMWRITE->FETCH
- EXECR->ALUWB; EXECI->ALUWB; JAL->ALUWB; ALUWB->FETCH; BEQ->FETCH
REQ-006 Per-state outputs SHALL be as follows; any field not listed is 0, and there are no don't-cares:
- FETCH: adrsrc=0, irwrite=1, alusrca=00, alusrcb=10, aluop=00, resultsrc=10, pcupdate=1
- DECODE: alusrca=01, alusrcb=01, aluop=00
- MEMADR: alusrca=10, alusrcb=01, aluop=00
- MEMREAD: resultsrc=00, adrsrc=1
- MEMWB: resultsrc=01, regwrite=1
- MEMWRITE: resultsrc=00, adrsrc=1, memwrite=1
- EXECR: alusrca=10, alusrcb=00, aluop=10
- EXECI: alusrca=10, alusrcb=01, aluop=10
- ALUWB: resultsrc=00, regwrite=1
- BEQ: alusrca=10, alusrcb=00, aluop=01, resultsrc=00, branch=1
- JAL: alusrca=01, alusrcb=10, aluop=00, resultsrc=00, pcupdate=1
REQ-007 pcupdate and branch SHALL be internal signals; pcwrite SHALL equal pcupdate OR (branch AND zero), evaluated combinationally within the cycle.
REQ-008 illegal SHALL be 1 exactly in a DECODE cycle whose op matches none of the six listed opcodes, and 0 in all other cycles.
REQ-009 op SHALL be sampled only in DECODE and MEMADR; op changing in any other state SHALL have no effect.
REQ-010 Instruction latency in cycles SHALL be: lw 5, sw 4, R-type 4, I-type 4, jal 4, beq 3, illegal 2.

Reset
REQ-011 Asserting reset SHALL move the state to FETCH immediately, without waiting for a clock edge, including mid-instruction.
REQ-012 While reset is 1, irwrite, pcwrite, regwrite, memwrite and illegal SHALL be forced to 0, and the selects and aluop SHALL show FETCH values.
REQ-013 After reset deasserts, the first rising edge SHALL execute FETCH as a normal cycle, with irwrite=1 and pcwrite=1.

Verification
REQ-014 The bench SHALL cover these scenarios:
- reset pulse, then op=0000011 held -> states FETCH,DECODE,MEMADR,MEMREAD,MEMWB,FETCH; regwrite=1 only in MEMWB; resultsrc=01 there
- op=0100011 -> FETCH,DECODE,MEMADR,MEMWRITE,FETCH; memwrite=1 for exactly 1 cycle with adrsrc=1
- op=1100011: zero=1 -> pcwrite=1 in BEQ with aluop=01; zero=0 -> pcwrite=0 in BEQ
- op=0110011 then 0010011 -> aluop=10 in EXECR and EXECI; alusrcb=00 and 01 respectively; ALUWB follows each
- op=1101111 -> JAL with pcwrite=1, alusrca=01, alusrcb=10, then ALUWB with regwrite=1
- op=1111111 -> illegal=1 for 1 cycle in DECODE, then FETCH; reset asserted asynchronously in MEMREAD -> FETCH before the next edge, all enables 0
